// File: rtl/floppy_sector_loader.sv
// rtl/floppy_sector_loader.sv - loads one floppy sector from block storage into the sector buffer
module floppy_sector_loader #(
    parameter int          SECTOR_SIZE       = 512,
    parameter int          SECTORS_PER_TRACK = 10,
    parameter int          MAX_TRACK         = 82,
    parameter logic [15:0] BASE_LBA          = 16'h0000,
    parameter logic [23:0] TIMEOUT           = 24'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clken,
    input  logic [7:0] cpu_command,
    input  logic [7:0] track,
    input  logic [7:0] sector,
    output logic [7:0] cpu_status,
    output logic       busy,
    output logic       blk_req,
    output logic [15:0] blk_lba,
    input  logic       blk_valid,
    input  logic [7:0] blk_data,
    input  logic       blk_err,
    output logic [8:0] buf_addr,
    output logic       buf_wr,
    output logic [7:0] buf_data
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_CALC = 2'd1;
    localparam logic [1:0]  S_XFER = 2'd2;
    localparam logic [1:0]  S_DONE = 2'd3;

    localparam logic [8:0]  LAST_BYTE = 9'(SECTOR_SIZE - 1);
    localparam logic [15:0] SPT       = 16'(SECTORS_PER_TRACK);
    localparam logic [7:0]  MAXT      = 8'(MAX_TRACK);
    localparam logic [23:0] TMO_LAST  = TIMEOUT - 24'd1;

    // Constant multiply by sectors-per-track unrolled into shifted adds.
    function automatic logic [15:0] mul_spt(input logic [15:0] v);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (SPT[i]) acc = acc + (v << i);
        end
        return acc;
    endfunction

    logic [1:0]  state;
    logic        lat_side;
    logic [7:0]  lat_track;
    logic [7:0]  lat_sector;
    logic [8:0]  byte_cnt;
    logic [23:0] tmo_cnt;

    logic [15:0] track_side;
    logic [15:0] lba_calc;
    logic        geometry_bad;
    logic        is_read;
    logic        is_ack;

    assign track_side   = {7'd0, lat_track, lat_side};
    assign lba_calc     = BASE_LBA + mul_spt(track_side) + {8'd0, lat_sector} - 16'd1;
    assign geometry_bad = (lat_sector == 8'd0) || ({8'd0, lat_sector} > SPT) || (lat_track > MAXT);
    assign is_read      = !cpu_command[7] && cpu_command[4];
    assign is_ack       = (cpu_command == 8'h80);
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_side   <= 1'b0;
            lat_track  <= 8'd0;
            lat_sector <= 8'd0;
            byte_cnt   <= 9'd0;
            tmo_cnt    <= 24'd0;
            cpu_status <= 8'h00;
            blk_req    <= 1'b0;
            blk_lba    <= 16'd0;
            buf_addr   <= 9'd0;
            buf_wr     <= 1'b0;
            buf_data   <= 8'd0;
        end else if (clken) begin
            // Write strobe lives for exactly one enabled cycle.
            buf_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (is_read) begin
                        lat_side   <= cpu_command[0];
                        lat_track  <= track;
                        lat_sector <= sector;
                        state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (geometry_bad) begin
                        cpu_status <= 8'h01;
                        state      <= S_DONE;
                    end else begin
                        blk_lba  <= lba_calc;
                        blk_req  <= 1'b1;
                        byte_cnt <= 9'd0;
                        tmo_cnt  <= 24'd0;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    // An error in the same cycle as data discards the byte.
                    if (blk_err) begin
                        blk_req    <= 1'b0;
                        cpu_status <= 8'h01;
                        state      <= S_DONE;
                    end else if (blk_valid) begin
                        buf_wr   <= 1'b1;
                        buf_addr <= byte_cnt;
                        buf_data <= blk_data;
                        byte_cnt <= byte_cnt + 9'd1;
                        tmo_cnt  <= 24'd0;
                        if (byte_cnt == LAST_BYTE) begin
                            blk_req    <= 1'b0;
                            cpu_status <= 8'h03;
                            state      <= S_DONE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        blk_req    <= 1'b0;
                        cpu_status <= 8'h01;
                        state      <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
                end
                S_DONE: begin
                    if (is_ack) begin
                        cpu_status <= 8'h00;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floppy_sector_loader.sv
// tb/tb_floppy_sector_loader.sv - directed self-checking bench for floppy_sector_loader
module tb_floppy_sector_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic [7:0]  cpu_command;
    logic [7:0]  track;
    logic [7:0]  sector;
    logic [7:0]  cpu_status;
    logic        busy;
    logic        blk_req;
    logic [15:0] blk_lba;
    logic        blk_valid;
    logic [7:0]  blk_data;
    logic        blk_err;
    logic [8:0]  buf_addr;
    logic        buf_wr;
    logic [7:0]  buf_data;

    int          vectors = 0;
    int          miscompares = 0;
    int          wr_count = 0;
    int          pulses = 0;
    logic        prev_wr = 1'b0;
    logic [8:0]  exp_addr = 9'd0;
    logic        toggle = 1'b0;

    floppy_sector_loader #(.TIMEOUT(24'd16)) dut (
        .clk(clk), .reset(reset), .clken(clken),
        .cpu_command(cpu_command), .track(track), .sector(sector),
        .cpu_status(cpu_status), .busy(busy),
        .blk_req(blk_req), .blk_lba(blk_lba),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_err(blk_err),
        .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_data(buf_data)
    );

    always #5 clk = ~clk;

    // Every buffer write seen by the next enabled edge is checked against the expected index.
    always @(negedge clk) begin
        if (clken && buf_wr) begin
            wr_count++;
            vectors++;
            if (buf_addr !== exp_addr || buf_data !== exp_addr[7:0]) begin
                miscompares++;
                $display("FAIL buf_write: addr=%0d data=%0h, expected addr=%0d data=%0h",
                         buf_addr, buf_data, exp_addr, exp_addr[7:0]);
            end
            exp_addr = exp_addr + 9'd1;
        end
        if (buf_wr && !prev_wr) pulses++;
        prev_wr = buf_wr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ce_cycle();
        if (toggle) begin
            clken = 1'b1; step();
            clken = 1'b0; step();
        end else begin
            clken = 1'b1; step();
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic err);
        blk_valid = 1'b1; blk_data = d; blk_err = err;
        ce_cycle();
        blk_valid = 1'b0; blk_err = 1'b0;
    endtask

    // Command is removed and geometry scrambled after sampling; only latched values may matter.
    task automatic start_read(input logic [7:0] cmd, input logic [7:0] trk, input logic [7:0] sec);
        exp_addr = 9'd0;
        cpu_command = cmd; track = trk; sector = sec;
        ce_cycle();
        cpu_command = 8'h00; track = 8'hEE; sector = 8'hEE;
        ce_cycle();
    endtask

    task automatic ack();
        cpu_command = 8'h80;
        ce_cycle();
        cpu_command = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1; clken = 1'b0;
        step(); step();
        reset = 1'b0;
        vectors++; if (cpu_status !== 8'h00) begin miscompares++; $display("FAIL reset_status: got %0h want 00", cpu_status); end
        vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        vectors++; if (blk_req !== 1'b0)     begin miscompares++; $display("FAIL reset_req: got %0b want 0", blk_req); end
        vectors++; if (blk_lba !== 16'd0)    begin miscompares++; $display("FAIL reset_lba: got %0d want 0", blk_lba); end
        vectors++; if (buf_addr !== 9'd0)    begin miscompares++; $display("FAIL reset_addr: got %0d want 0", buf_addr); end
        vectors++; if (buf_wr !== 1'b0)      begin miscompares++; $display("FAIL reset_wr: got %0b want 0", buf_wr); end
        vectors++; if (buf_data !== 8'd0)    begin miscompares++; $display("FAIL reset_data: got %0h want 00", buf_data); end
    endtask

    task automatic test_good_read();
        int base;
        base = wr_count;
        exp_addr = 9'd0;
        cpu_command = 8'h11; track = 8'd3; sector = 8'd5;
        ce_cycle();
        cpu_command = 8'h00; track = 8'hEE; sector = 8'hEE;
        vectors++; if (blk_req !== 1'b0) begin miscompares++; $display("FAIL latency_early: blk_req=%0b want 0", blk_req); end
        vectors++; if (busy !== 1'b1)    begin miscompares++; $display("FAIL good_busy: got %0b want 1", busy); end
        ce_cycle();
        vectors++; if (blk_req !== 1'b1) begin miscompares++; $display("FAIL latency_req: blk_req=%0b want 1", blk_req); end
        vectors++; if (blk_lba !== 16'd74) begin miscompares++; $display("FAIL good_lba: got %0d want 74", blk_lba); end
        for (int i = 0; i < 512; i++) begin
            send_byte(8'(i), 1'b0);
            if (i == 255) begin
                vectors++;
                if (blk_req !== 1'b1 || blk_lba !== 16'd74) begin
                    miscompares++; $display("FAIL good_stable: req=%0b lba=%0d want 1/74", blk_req, blk_lba);
                end
            end
        end
        vectors++; if (blk_req !== 1'b0)      begin miscompares++; $display("FAIL good_req_drop: got %0b want 0", blk_req); end
        vectors++; if (cpu_status !== 8'h03)  begin miscompares++; $display("FAIL good_status: got %0h want 03", cpu_status); end
        cpu_command = 8'h55;
        ce_cycle();
        vectors++; if (cpu_status !== 8'h03 || busy !== 1'b1) begin miscompares++; $display("FAIL done_ignore: status=%0h busy=%0b want 03/1", cpu_status, busy); end
        vectors++; if (wr_count - base !== 512) begin miscompares++; $display("FAIL good_count: got %0d want 512", wr_count - base); end
        ack();
        vectors++; if (cpu_status !== 8'h00 || busy !== 1'b0) begin miscompares++; $display("FAIL good_ack: status=%0h busy=%0b want 00/0", cpu_status, busy); end
    endtask

    task automatic test_bad_geometry();
        logic [7:0] trks [3] = '{8'd3, 8'd3, 8'd83};
        logic [7:0] secs [3] = '{8'd0, 8'd11, 8'd1};
        for (int k = 0; k < 3; k++) begin
            start_read(8'h10, trks[k], secs[k]);
            vectors++; if (blk_req !== 1'b0) begin miscompares++; $display("FAIL bad_geo_req[%0d]: got %0b want 0", k, blk_req); end
            vectors++; if (cpu_status !== 8'h01) begin miscompares++; $display("FAIL bad_geo_status[%0d]: got %0h want 01", k, cpu_status); end
            ack();
        end
    endtask

    task automatic test_storage_error();
        int base;
        base = wr_count;
        start_read(8'h10, 8'd0, 8'd1);
        vectors++; if (blk_lba !== 16'd0 || blk_req !== 1'b1) begin miscompares++; $display("FAIL err_start: lba=%0d req=%0b want 0/1", blk_lba, blk_req); end
        for (int i = 0; i < 100; i++) send_byte(8'(i), 1'b0);
        send_byte(8'd100, 1'b1);
        vectors++; if (blk_req !== 1'b0) begin miscompares++; $display("FAIL err_req: got %0b want 0", blk_req); end
        vectors++; if (cpu_status !== 8'h01) begin miscompares++; $display("FAIL err_status: got %0h want 01", cpu_status); end
        send_byte(8'h77, 1'b0);
        send_byte(8'h78, 1'b1);
        ce_cycle();
        vectors++; if (wr_count - base !== 100) begin miscompares++; $display("FAIL err_count: got %0d want 100", wr_count - base); end
        vectors++; if (cpu_status !== 8'h01 || busy !== 1'b1) begin miscompares++; $display("FAIL err_outside: status=%0h busy=%0b want 01/1", cpu_status, busy); end
        ack();
    endtask

    task automatic test_timeout();
        int base;
        int n;
        base = wr_count;
        start_read(8'h10, 8'd0, 8'd2);
        vectors++; if (blk_lba !== 16'd1) begin miscompares++; $display("FAIL tmo_lba: got %0d want 1", blk_lba); end
        n = 0;
        while (n < 100 && cpu_status !== 8'h01) begin
            ce_cycle();
            n++;
        end
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL tmo_cycles: got %0d want 16", n); end
        vectors++; if (blk_req !== 1'b0) begin miscompares++; $display("FAIL tmo_req: got %0b want 0", blk_req); end
        send_byte(8'h42, 1'b0);
        ce_cycle();
        vectors++; if (wr_count !== base) begin miscompares++; $display("FAIL tmo_late: writes=%0d want %0d", wr_count, base); end
        ack();
    endtask

    task automatic test_back_to_back();
        int base_w;
        int base_p;
        base_w = wr_count; base_p = pulses;
        toggle = 1'b1;
        start_read(8'h10, 8'd0, 8'd9);
        vectors++; if (blk_req !== 1'b1 || blk_lba !== 16'd8) begin miscompares++; $display("FAIL multi_lba0: req=%0b lba=%0d want 1/8", blk_req, blk_lba); end
        for (int i = 0; i < 512; i++) begin send_byte(8'(i), 1'b0); ce_cycle(); end
        vectors++; if (cpu_status !== 8'h03) begin miscompares++; $display("FAIL multi_status0: got %0h want 03", cpu_status); end
        ack();
        exp_addr = 9'd0;
        cpu_command = 8'h10; track = 8'd0; sector = 8'd10;
        ce_cycle();
        cpu_command = 8'h00;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL multi_accept: busy=%0b want 1", busy); end
        ce_cycle();
        vectors++; if (blk_req !== 1'b1 || blk_lba !== 16'd9) begin miscompares++; $display("FAIL multi_lba1: req=%0b lba=%0d want 1/9", blk_req, blk_lba); end
        for (int i = 0; i < 512; i++) begin send_byte(8'(i), 1'b0); ce_cycle(); end
        vectors++; if (cpu_status !== 8'h03) begin miscompares++; $display("FAIL multi_status1: got %0h want 03", cpu_status); end
        vectors++; if (wr_count - base_w !== 1024) begin miscompares++; $display("FAIL multi_writes: got %0d want 1024", wr_count - base_w); end
        vectors++; if (pulses - base_p !== 1024) begin miscompares++; $display("FAIL multi_pulses: got %0d want 1024", pulses - base_p); end
        ack();
        toggle = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        start_read(8'h11, 8'd1, 8'd3);
        vectors++; if (blk_lba !== 16'd32) begin miscompares++; $display("FAIL mid_lba: got %0d want 32", blk_lba); end
        for (int i = 0; i <= 200; i++) send_byte(8'(i), 1'b0);
        reset = 1'b1; clken = 1'b0;
        step();
        reset = 1'b0;
        vectors++;
        if (blk_req !== 1'b0 || busy !== 1'b0 || cpu_status !== 8'h00 || blk_lba !== 16'd0 ||
            buf_addr !== 9'd0 || buf_wr !== 1'b0 || buf_data !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset: req=%0b busy=%0b st=%0h lba=%0d addr=%0d wr=%0b data=%0h want all 0",
                     blk_req, busy, cpu_status, blk_lba, buf_addr, buf_wr, buf_data);
        end
        base = wr_count;
        send_byte(8'd201, 1'b0);
        ce_cycle();
        vectors++; if (wr_count !== base || busy !== 1'b0) begin miscompares++; $display("FAIL mid_ignore: writes=%0d busy=%0b want %0d/0", wr_count, busy, base); end
        start_read(8'h10, 8'd0, 8'd1);
        send_byte(8'd0, 1'b0);
        ce_cycle();
        vectors++; if (wr_count - base !== 1) begin miscompares++; $display("FAIL mid_restart: writes=%0d want 1", wr_count - base); end
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clken = 1'b0; cpu_command = 8'h00; track = 8'd0; sector = 8'd0;
        blk_valid = 1'b0; blk_data = 8'd0; blk_err = 1'b0;
        test_reset();
        test_good_read();
        test_bad_geometry();
        test_storage_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/floppy_sector_loader.md
FLOPPY_SECTOR_LOADER -- requirements
Module: floppy_sector_loader

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- SECTOR_SIZE, 512, bytes per sector and per storage block.
- SECTORS_PER_TRACK, 10, sectors per track per side.
- MAX_TRACK, 82, highest valid track number.
- BASE_LBA, 16'h0000, storage block address of track 0 / side 0 / sector 1.
- TIMEOUT, 24'd1000000, maximum clken cycles without a storage byte.

REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first. There is one clock; reset is synchronous and active-high.
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- clken, in, 1, clock enable; all state advances only on clk edges where clken=1.
- cpu_command, in, 8, command from the FDC:
  - 8'h1x is READ, with bit0 = side.
  - 8'h80 is ACK.
- track, in, 8, FDC head position.
- sector, in, 8, FDC sector register (1-based).
- cpu_status, out, 8, status to the FDC:
  - bit0 = done.
  - bit1 = success.
  - other bits 0.
- busy, out, 1, high in every state except IDLE.
- blk_req, out, 1, storage read request.
- blk_lba, out, 16, storage block address.
- blk_valid, in, 1, one data byte present on blk_data.
- blk_data, in, 8, storage data byte.
- blk_err, in, 1, storage read failure.
- buf_addr, out, 9, sector buffer write address.
- buf_wr, out, 1, sector buffer write strobe.
- buf_data, out, 8, sector buffer write data.

Function
REQ-003 The state machine SHALL have four states: IDLE, CALC, XFER, DONE.

REQ-004 IDLE: when cpu_command[7]=0 and cpu_command[4]=1, the block SHALL latch the side (cpu_command[0]), track and sector, then go to CALC.

REQ-005 CALC (one cycle):
- If sector=0, sector>SECTORS_PER_TRACK or track>MAX_TRACK, the block SHALL go to DONE with failure and SHALL NOT assert blk_req.
- Otherwise it SHALL compute blk_lba = BASE_LBA + (track*2+side)*SECTORS_PER_TRACK + sector-1, modulo 2^16, using no hardware multiplier (shift-add only).
- It SHALL then assert blk_req, clear the byte counter and timeout counter, and go to XFER.

REQ-006 Latency: blk_req SHALL rise 2 clken cycles after the cycle in which the READ command is first sampled.

REQ-007 XFER: blk_req and blk_lba SHALL remain stable until XFER is left.

REQ-008 Each blk_valid in XFER SHALL produce, on the next cycle:
- buf_wr=1 for exactly one clken cycle;
- buf_addr = byte counter;
- buf_data = blk_data;
- byte counter incremented;
- timeout counter cleared.

REQ-009 When the byte at counter value SECTOR_SIZE-1 is accepted, the block SHALL drop blk_req and go to DONE with success.

REQ-010 blk_err in XFER SHALL drop blk_req and go to DONE with failure; a blk_valid in the same cycle SHALL NOT be written (error wins, including on the last byte).

REQ-011 When the timeout counter reaches TIMEOUT with no blk_valid, the block SHALL drop blk_req and go to DONE with failure.

REQ-012 DONE output: cpu_status SHALL read 8'h03 on success and 8'h01 on failure.

REQ-013 DONE exit: on cpu_command=8'h80, cpu_status SHALL clear to 8'h00 and the block SHALL return to IDLE.

REQ-014 Any other cpu_command value in DONE SHALL be ignored.

REQ-015 A READ presented directly after ACK (multisector) SHALL be accepted from IDLE on the cycle after the return to IDLE.

REQ-016 blk_valid or blk_err outside XFER SHALL be ignored, with no buffer write and no state change.

REQ-017 cpu_command changes outside IDLE and DONE SHALL be ignored; track and sector are used only as latched values.

REQ-018 With clken=0, all registers and outputs SHALL hold; buf_wr SHALL NOT be re-asserted on the same pending byte.

Reset
REQ-019 While reset=1 at a clk edge, the block SHALL, regardless of clken:
- enter IDLE;
- set cpu_status=8'h00, busy=0, blk_req=0, blk_lba=0, buf_addr=0, buf_wr=0, buf_data=0;
- clear all counters.

REQ-020 Reset during XFER SHALL drop blk_req on the same edge; bytes arriving afterwards SHALL be ignored.

Verification
REQ-021 Good read: track=3, sector=5, cpu_command=8'h11, storage returns 512 bytes of value i[7:0] -> blk_lba=16'd74, buf_addr 0..511 with buf_data=i[7:0], cpu_status=8'h03; after 8'h80, cpu_status=8'h00 and busy=0.

REQ-022 Bad geometry:
- sector=0 with cpu_command=8'h10 -> blk_req never high, cpu_status=8'h01.
- sector=11 -> same response.
- track=83 -> same response.

REQ-023 Storage error: blk_err asserted with blk_valid on byte 100 -> 100 buffer writes (0..99), blk_req low, cpu_status=8'h01.

REQ-024 Timeout (TIMEOUT=16 in test): blk_req high with no blk_valid -> DONE after 16 clken cycles, cpu_status=8'h01; a late blk_valid causes no buf_wr.

REQ-025 Multisector and clken: READ sector 9, ACK, READ sector 10 back-to-back with clken toggling 1/0 -> blk_lba 8 then 9, exactly 1024 buf_wr pulses, each one clken cycle long.

REQ-026 Reset mid-transfer: reset asserted after byte 200 -> all outputs 0 on the next edge; a following READ restarts at buf_addr=0.
